// File: rtl/fixedpoint_pkg.sv
// Shared types and helpers for the signed fixed-point add/sub datapath.
// Saturation constants are built here so every width uses the same definition.
package fixedpoint_pkg;

    // Operation select carried alongside each transaction.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } fixedpoint_op_t;

    // Widest word the saturation helper can describe; callers slice the low bits.
    localparam int FP_MAX_W = 64;

    // Saturation bound for a signed word of 'width' bits:
    // negative=0 gives max (0 followed by ones), negative=1 gives min (1 followed by zeros).
    function automatic logic [FP_MAX_W-1:0] fp_sat_value(input int width, input logic negative);
        logic [FP_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < FP_MAX_W; i++) begin
            if (i < width - 1) begin
                v[i] = ~negative;
            end else if (i == width - 1) begin
                v[i] = negative;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/fixedpoint_pipe_stage.sv
// Generic valid/ready register slice.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// The slice loads whenever it is empty or its content is leaving this cycle, so a
// chain of slices runs at full rate; in_ready_o is combinational from out_ready_i.
module fixedpoint_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             load;

    // Next-state: take new content when empty or draining; data only moves with a valid beat.
    always_comb begin
        load    = !valid_q || out_ready_i;
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
    end

    // State register with synchronous clear of both valid and data.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign in_ready_o  = load;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/fixedpoint_addsub.sv
// Signed fixed-point adder/subtractor, Q(wholeWidth).(fractionWidth), two-stage
// valid/ready pipeline. Stage 1 holds the W+1-bit sum, stage 2 holds result+overflow.
// Optional build macro FIXEDPOINT_SATURATE_EN clamps overflowed results to max/min;
// without it results wrap modulo 2^W. Overflow is flagged in both builds.
module fixedpoint_addsub
    import fixedpoint_pkg::*;
#(
    parameter  int wholeWidth    = 4,
    parameter  int fractionWidth = 4,
    localparam int W             = wholeWidth + fractionWidth
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_op,
    input  logic [W-1:0] valueOne,
    input  logic [W-1:0] valueTwo,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         overflow
);

    fixedpoint_op_t op;
    logic [W:0]     a_ext, b_ext, b_eff, cin, sum;
    logic           s1_valid, s1_ready, s2_ready;
    logic [W:0]     s1_data;
    logic           ovf_next;
    logic [W-1:0]   res_next;
    logic [W:0]     s2_data;

    assign op = fixedpoint_op_t'(in_op);

    // Full-word sign-extended add; subtraction is A + ~B + 1 so borrow crosses the binary point.
    always_comb begin
        a_ext = {valueOne[W-1], valueOne};
        b_ext = {valueTwo[W-1], valueTwo};
        b_eff = b_ext;
        cin   = '0;
        if (op == OP_SUB) begin
            b_eff  = ~b_ext;
            cin[0] = 1'b1;
        end
        sum = a_ext + b_eff + cin;
    end

    fixedpoint_pipe_stage #(.WIDTH(W + 1)) u_stage1 (
        .clock_i     (clock),
        .reset_i     (reset),
        .in_valid_i  (in_valid),
        .in_ready_o  (s1_ready),
        .in_data_i   (sum),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_ready),
        .out_data_o  (s1_data)
    );

    assign ovf_next = s1_data[W] ^ s1_data[W-1];

`ifdef FIXEDPOINT_SATURATE_EN
    logic [FP_MAX_W-1:0] sat_full;

    // Clamp toward the sign of the true (extended) sum when it does not fit in W bits.
    always_comb begin
        sat_full = fp_sat_value(W, s1_data[W]);
        res_next = s1_data[W-1:0];
        if (ovf_next) begin
            res_next = sat_full[W-1:0];
        end
    end
`else
    // Wrap: keep the low W bits of the extended sum.
    always_comb begin
        res_next = s1_data[W-1:0];
    end
`endif

    fixedpoint_pipe_stage #(.WIDTH(W + 1)) u_stage2 (
        .clock_i     (clock),
        .reset_i     (reset),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s2_ready),
        .in_data_i   ({ovf_next, res_next}),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (s2_data)
    );

    assign in_ready = s1_ready;
    assign result   = s2_data[W-1:0];
    assign overflow = s2_data[W];

endmodule

// File: tb/tb_fixedpoint_addsub.sv
// Directed bench for fixedpoint_addsub at Q4.4 (W=8).
// Honours FIXEDPOINT_SATURATE_EN for expected results.
module tb_fixedpoint_addsub;
    import fixedpoint_pkg::*;

    localparam int W = 8;

`ifdef FIXEDPOINT_SATURATE_EN
    localparam logic [W-1:0] EXP_POS = 8'h7F;
    localparam logic [W-1:0] EXP_NEG = 8'h80;
`else
    localparam logic [W-1:0] EXP_POS = 8'h88;
    localparam logic [W-1:0] EXP_NEG = 8'h7F;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_op = 1'b0;
    logic [W-1:0] value_one = '0;
    logic [W-1:0] value_two = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         overflow;

    logic [W:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int out_count = 0;
    int stall_count = 0;

    fixedpoint_addsub #(.wholeWidth(4), .fractionWidth(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .valueOne  (value_one),
        .valueTwo  (value_two),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then range check and wrap/clamp. Returns {ovf, result}.
    function automatic logic [W:0] model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        int          sa, sb, s;
        logic [31:0] sv;
        logic        ovf;
        logic [W-1:0] r;
        sa  = $signed(a);
        sb  = $signed(b);
        s   = op ? (sa - sb) : (sa + sb);
        ovf = (s > 127) || (s < -128);
        sv  = s;
        r   = sv[W-1:0];
`ifdef FIXEDPOINT_SATURATE_EN
        if (s > 127)  r = 8'h7F;
        if (s < -128) r = 8'h80;
`endif
        return {ovf, r};
    endfunction

    // Driver: present one transaction, wait (bounded) for acceptance, record expectation.
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        int waited = 0;
        in_valid  = 1'b1;
        in_op     = op;
        value_one = a;
        value_two = b;
        @(negedge clock);
        while (!in_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (waited > 0) stall_count++;
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            exp_q.push_back(model(op, a, b));
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        #1;
    endtask

    // Scoreboard: every output beat that transfers is compared against the queue head.
    initial begin
        logic [W:0] e;
        forever begin
            @(negedge clock);
            if (!reset && out_valid && out_ready) begin
                out_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_result", 32'(result), 32'(e[W-1:0]));
                    check("stream_overflow", 32'(overflow), 32'(e[W]));
                end
            end
        end
    end

    initial begin
        int c;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Borrow across binary point and two-cycle latency
        send(OP_SUB, 8'h18, 8'h0C);
        check("lat_edge1_valid", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1;
        check("lat_edge2_valid", 32'(out_valid), 32'd1);
        check("borrow_result", 32'(result), 32'h0C);
        check("borrow_overflow", 32'(overflow), 32'd0);
        drain();

        // Positive overflow
        send(OP_ADD, 8'h78, 8'h10);
        @(posedge clock);
        #1;
        check("pos_ovf_result", 32'(result), 32'(EXP_POS));
        check("pos_ovf_flag", 32'(overflow), 32'd1);
        drain();

        // Negative overflow
        send(OP_SUB, 8'h80, 8'h01);
        @(posedge clock);
        #1;
        check("neg_ovf_result", 32'(result), 32'(EXP_NEG));
        check("neg_ovf_flag", 32'(overflow), 32'd1);
        drain();

        // Backpressure: two accepts fill the pipe, then input stalls and output holds
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 5; i++) send(OP_ADD, 8'(i), 8'(i));
            end
        join_none
        repeat (2) @(posedge clock);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_hold_result", 32'(result), 32'h02);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        wait fork;
        drain();

        // Full-rate random stream
        stall_count = 0;
        c = out_count;
        for (int i = 0; i < 16; i++) begin
            send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        check("fullrate_stalls", 32'(stall_count), 32'd0);
        drain();
        check("fullrate_count", 32'(out_count - c), 32'd16);

        // Reset with two transactions in flight
        out_ready = 1'b0;
        send(OP_ADD, 8'h11, 8'h22);
        send(OP_SUB, 8'h33, 8'h01);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        c = out_count;
        repeat (6) @(posedge clock);
        #1;
        check("midrst_no_emit", 32'(out_count - c), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
